// File: rtl/wire_pkg.sv
// Shared definitions for the single-wire peripherals: FSM states, register offsets,
// CTRL/STATUS bit positions and the word alignment helper used when a frame starts.
package wire_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_START_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_STOP_LOW
  } wire_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_LEN_W      = 6;
  localparam int CTRL_IE_BIT     = 8;
  localparam int CTRL_START_BIT  = 31;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_LINE_BIT = 2;

  // LEN of 0 (or anything above 32) sends the whole word.
  function automatic logic [5:0] eff_len(input logic [5:0] len);
    return ((len == 6'd0) || (len > 6'd32)) ? 6'd32 : len;
  endfunction

  // Moves bit LEN-1 up to bit 31 so the transmitter can always shift out of the MSB.
  function automatic logic [31:0] align_msb(input logic [31:0] word, input logic [5:0] len);
    logic [5:0] sh;
    sh = 6'd32 - eff_len(len);
    return word << sh;
  endfunction

endpackage

// File: rtl/wire_tx_apb_if.sv
// APB3 slave-side bundle for the single-wire transmitter.
interface wire_tx_apb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/wire_tx_timer.sv
// Phase timer: loadable down-counter that parks at zero and flags it.
module wire_tx_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wire_tx_apb.sv
// APB3 slave that sends a CPU-supplied word MSB first as a pulse-width-coded frame
// on the open-drain single-wire line (start pulse, data bits, stop pulse).
module wire_tx_apb
  import wire_pkg::*;
#(
  parameter int CNT_W          = 20,
  parameter int START_LOW_CYC  = 720000,
  parameter int START_HIGH_CYC = 1600,
  parameter int BIT_LOW_CYC    = 2000,
  parameter int ZERO_HIGH_CYC  = 1040,
  parameter int ONE_HIGH_CYC   = 2800,
  parameter int STOP_LOW_CYC   = 2000
) (
  input  logic           PCLK,
  input  logic           PRESERN,
  wire_tx_apb_if.slave   apb,
  output logic           irq,
  inout  wire            data
);

  wire_state_e     state_q, state_d;
  logic [31:0]     data_q;
  logic [5:0]      len_q;
  logic            ie_q;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [31:0]     shift_q, shift_d;
  logic [5:0]      bitcnt_q, bitcnt_d;
  logic            sync1_q, sync2_q;

  logic [1:0]      addr;
  logic            access, wr, wr_data, wr_ctrl, start, w1c;
  logic            drive_low, frame_end, tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic            unused_addr;

  assign addr        = apb.PADDR[3:2];
  assign unused_addr = ^{apb.PADDR[31:4], apb.PADDR[1:0]};

  // APB decode; DATA/CTRL are frozen while a frame is on the wire
  always_comb begin
    access      = apb.PSEL & apb.PENABLE;
    wr          = access & apb.PWRITE;
    wr_data     = wr & (addr == REG_DATA) & ~busy_q;
    wr_ctrl     = wr & (addr == REG_CTRL) & ~busy_q;
    start       = wr_ctrl & apb.PWDATA[CTRL_START_BIT];
    w1c         = wr & (addr == REG_STATUS) & apb.PWDATA[STATUS_DONE_BIT];
    apb.PREADY  = 1'b1;
    apb.PSLVERR = access & ((addr == 2'b11) |
                  (apb.PWRITE & busy_q & ((addr == REG_DATA) | (addr == REG_CTRL))));
  end

  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (addr)
        REG_DATA: apb.PRDATA = data_q;
        REG_CTRL: begin
          apb.PRDATA[CTRL_LEN_W-1:0] = len_q;
          apb.PRDATA[CTRL_IE_BIT]    = ie_q;
        end
        REG_STATUS: begin
          apb.PRDATA[STATUS_BUSY_BIT] = busy_q;
          apb.PRDATA[STATUS_DONE_BIT] = done_q;
          apb.PRDATA[STATUS_LINE_BIT] = sync2_q;
        end
        default: apb.PRDATA = '0;
      endcase
    end
  end

  // Each phase loads (length - 1) on entry and advances when the timer reaches zero
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    drive_low = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_START_LOW;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(START_LOW_CYC - 1);
          shift_d  = align_msb(data_q, apb.PWDATA[CTRL_LEN_W-1:0]);
          bitcnt_d = eff_len(apb.PWDATA[CTRL_LEN_W-1:0]);
        end
      end
      ST_START_LOW: begin
        drive_low = 1'b1;
        if (tmr_zero) begin
          state_d  = ST_START_HIGH;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(START_HIGH_CYC - 1);
        end
      end
      ST_START_HIGH: begin
        if (tmr_zero) begin
          state_d  = ST_BIT_LOW;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(BIT_LOW_CYC - 1);
        end
      end
      ST_BIT_LOW: begin
        drive_low = 1'b1;
        if (tmr_zero) begin
          state_d  = ST_BIT_HIGH;
          tmr_load = 1'b1;
          tmr_val  = shift_q[31] ? CNT_W'(ONE_HIGH_CYC - 1) : CNT_W'(ZERO_HIGH_CYC - 1);
        end
      end
      ST_BIT_HIGH: begin
        if (tmr_zero) begin
          shift_d  = shift_q << 1;
          bitcnt_d = bitcnt_q - 6'd1;
          tmr_load = 1'b1;
          if (bitcnt_q == 6'd1) begin
            state_d = ST_STOP_LOW;
            tmr_val = CNT_W'(STOP_LOW_CYC - 1);
          end else begin
            state_d = ST_BIT_LOW;
            tmr_val = CNT_W'(BIT_LOW_CYC - 1);
          end
        end
      end
      ST_STOP_LOW: begin
        drive_low = 1'b1;
        if (tmr_zero) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // DONE set by the frame end wins over a same-cycle software clear
  always_comb begin
    busy_d = busy_q;
    if (start)          busy_d = 1'b1;
    else if (frame_end) busy_d = 1'b0;
    done_d = done_q;
    if (frame_end)        done_d = 1'b1;
    else if (start || w1c) done_d = 1'b0;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      len_q    <= '0;
      ie_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      sync1_q  <= data;
      sync2_q  <= sync1_q;
      if (wr_data) data_q <= apb.PWDATA;
      if (wr_ctrl) begin
        len_q <= apb.PWDATA[CTRL_LEN_W-1:0];
        ie_q  <= apb.PWDATA[CTRL_IE_BIT];
      end
    end
  end

  wire_tx_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (PCLK),
    .rst_ni     (PRESERN),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign irq  = done_q & ie_q;
  assign data = drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_wire_tx_apb.sv
// Directed bench for wire_tx_apb: APB register access and decoded frame shapes on the line.
module tb_wire_tx_apb;
  import wire_pkg::*;

  logic PCLK = 1'b0;
  logic PRESERN;
  logic irq;
  logic ext_low;
  wire  data_line;

  always #5 PCLK = ~PCLK;

  wire_tx_apb_if apb ();

  assign data_line = ext_low ? 1'b0 : 1'bz;
  pullup (data_line);

  wire_tx_apb #(
    .CNT_W(20), .START_LOW_CYC(20), .START_HIGH_CYC(4), .BIT_LOW_CYC(5),
    .ZERO_HIGH_CYC(3), .ONE_HIGH_CYC(7), .STOP_LOW_CYC(5)
  ) dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .apb     (apb),
    .irq     (irq),
    .data    (data_line)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge PCLK);
    err = apb.PSLVERR;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = a; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge PCLK);
    d   = apb.PRDATA;
    err = apb.PSLVERR;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  // Samples the line for ncyc cycles from the start commit and decodes the run lengths.
  task automatic capture(input int ncyc, output int total, output logic [31:0] word,
                         output int nbits, output int bad);
    logic s [0:1023];
    int   i, lo, hi;
    logic ended;
    total = 0; word = '0; nbits = 0; bad = 0; ended = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge PCLK);
      s[k] = data_line;
    end
    i = 0;
    lo = 0; while (i < ncyc && s[i] == 1'b0) begin lo++; i++; end
    hi = 0; while (i < ncyc && s[i] == 1'b1) begin hi++; i++; end
    if (lo != 20) bad++;
    if (hi != 4)  bad++;
    total = lo + hi;
    for (int b = 0; b < 40; b++) begin
      lo = 0; while (i < ncyc && s[i] == 1'b0) begin lo++; i++; end
      hi = 0; while (i < ncyc && s[i] == 1'b1) begin hi++; i++; end
      if (i >= ncyc) begin
        if (lo != 5) bad++;
        if (hi < 8)  bad++;
        total += lo;
        ended = 1'b1;
        break;
      end
      if (lo != 5) bad++;
      if (hi == 7)      word = {word[30:0], 1'b1};
      else if (hi == 3) word = {word[30:0], 1'b0};
      else              bad++;
      nbits++;
      total += lo + hi;
    end
    if (!ended) bad++;
  endtask

  logic [31:0] rd;
  logic        err, err1, err2;
  int          total, nbits, bad;
  logic [31:0] word;

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    ext_low = 1'b0;
    PRESERN = 1'b0;

    repeat (3) @(posedge PCLK);
    apb_read(32'h8, rd, err);
    chk("rst_status", rd, 32'h0);
    chk("rst_pslverr", {31'd0, err}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_line", {31'd0, data_line}, 32'd1);
    @(negedge PCLK); PRESERN = 1'b1;
    repeat (4) @(posedge PCLK);
    chk("pready", {31'd0, apb.PREADY}, 32'd1);

    apb_write(32'h4, 32'h0000_0108, err);
    apb_read(32'h4, rd, err);
    chk("ctrl_rb", rd, 32'h0000_0108);
    apb_write(32'h0, 32'h0000_00A5, err);
    apb_read(32'h0, rd, err);
    chk("data_rb", rd, 32'h0000_00A5);

    apb_read(32'hC, rd, err);
    chk("bad_addr_rd", rd, 32'h0);
    chk("bad_addr_err", {31'd0, err}, 32'd1);

    // 8-bit frame of 0xA5
    apb_write(32'h4, 32'h8000_0008, err);
    chk("a5_start_err", {31'd0, err}, 32'd0);
    capture(130, total, word, nbits, bad);
    chk("a5_total", total, 109);
    chk("a5_word", word, 32'h0000_00A5);
    chk("a5_nbits", nbits, 8);
    chk("a5_shape", bad, 0);
    apb_read(32'h8, rd, err);
    chk("a5_status", rd, 32'h6);
    apb_read(32'h4, rd, err);
    chk("a5_ctrl_rb", rd, 32'h8);
    chk("a5_irq_off", {31'd0, irq}, 32'd0);

    // LEN=0 sends all 32 bits
    apb_write(32'h0, 32'hFFFF_FFFF, err);
    apb_write(32'h4, 32'h8000_0000, err);
    capture(440, total, word, nbits, bad);
    chk("ff_total", total, 413);
    chk("ff_word", word, 32'hFFFF_FFFF);
    chk("ff_nbits", nbits, 32);
    chk("ff_shape", bad, 0);

    // LEN=4 ignores upper DATA bits; writes during the frame are refused
    apb_write(32'h0, 32'h0000_00F9, err);
    apb_write(32'h4, 32'h8000_0004, err);
    fork
      capture(90, total, word, nbits, bad);
      begin
        repeat (10) @(posedge PCLK);
        apb_write(32'h0, 32'h0000_0000, err1);
        apb_write(32'h4, 32'h8000_0001, err2);
        chk("busy_data_err", {31'd0, err1}, 32'd1);
        chk("busy_ctrl_err", {31'd0, err2}, 32'd1);
      end
    join
    chk("len4_total", total, 69);
    chk("len4_word", word, 32'h9);
    chk("len4_nbits", nbits, 4);
    chk("len4_shape", bad, 0);
    apb_read(32'h0, rd, err);
    chk("busy_data_kept", rd, 32'h0000_00F9);
    apb_read(32'h4, rd, err);
    chk("busy_ctrl_kept", rd, 32'h4);

    // interrupt and W1C
    apb_write(32'h8, 32'h2, err);
    apb_write(32'h4, 32'h8000_0104, err);
    chk("irq_busy", {31'd0, irq}, 32'd0);
    capture(90, total, word, nbits, bad);
    chk("irq_total", total, 69);
    chk("irq_set", {31'd0, irq}, 32'd1);
    apb_write(32'h8, 32'h2, err);
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // W1C landing on the DONE-set edge: set wins (LEN=1 frame = 41 cycles)
    apb_write(32'h0, 32'h0000_0001, err);
    apb_write(32'h4, 32'h8000_0101, err);
    repeat (38) @(posedge PCLK);
    apb_write(32'h8, 32'h2, err);
    apb_read(32'h8, rd, err);
    chk("w1c_race_status", rd, 32'h6);
    chk("w1c_race_irq", {31'd0, irq}, 32'd1);
    apb_write(32'h8, 32'h2, err);
    apb_read(32'h8, rd, err);
    chk("w1c_later", rd, 32'h4);

    // reset while a bit low pulse is on the line
    apb_write(32'h0, 32'h0000_00A5, err);
    apb_write(32'h4, 32'h8000_0008, err);
    repeat (26) @(posedge PCLK);
    #1;
    chk("midframe_low", {31'd0, data_line}, 32'd0);
    #2 PRESERN = 1'b0;
    #1;
    chk("rst_release", {31'd0, data_line}, 32'd1);
    apb_read(32'h8, rd, err);
    chk("rst2_status", rd, 32'h0);
    @(negedge PCLK); PRESERN = 1'b1;
    repeat (30) @(posedge PCLK);
    #1;
    chk("post_rst_line", {31'd0, data_line}, 32'd1);
    apb_read(32'h8, rd, err);
    chk("post_rst_status", rd, 32'h4);

    // external pull-low seen through the synchroniser
    ext_low = 1'b1;
    apb_read(32'h8, rd, err);
    chk("ext_low_sync", rd, 32'h0);
    ext_low = 1'b0;
    repeat (3) @(posedge PCLK);
    apb_read(32'h8, rd, err);
    chk("ext_rel_sync", rd, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
